// File: rtl/bus_arb2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb2_pkg
// Description : Shared constants, FSM state type and arbitration helper for
//               the two-requester single-slave bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arb2_pkg;

    localparam int         c_xlen        = 32;
    localparam logic [1:0] c_acc_byte    = 2'b00;
    localparam logic [1:0] c_acc_half    = 2'b01;
    localparam logic [1:0] c_acc_word    = 2'b10;
    localparam int         c_arb_fixed_d = 0;
    localparam int         c_arb_rr      = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT_I = 2'd1,
        ST_WAIT_D = 2'd2
    } state_t;

    // True when dbus should take the slave; only meaningful with a pending side.
    function automatic logic pick_dbus(input logic pend_i, input logic pend_d,
                                       input logic last_i, input logic rr_en);
        return pend_d & (~pend_i | ~rr_en | last_i);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arb2_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb2_if
// Description : One-cycle request / one-cycle response bus between a master
//               and a slave (core ibus, dbus or shared slave port).
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arb2_if
    import bus_arb2_pkg::*;
#(
    parameter int AW    = c_xlen,
    parameter int DW    = c_xlen,
    parameter int ACC_W = 2
) ();

    logic [AW-1:0]    addr;
    logic             w_rb;
    logic [ACC_W-1:0] acc;
    logic [DW-1:0]    wdata;
    logic             req;
    logic             resp;
    logic [DW-1:0]    rdata;
    logic             fault;

    modport master (
        output addr, w_rb, acc, wdata, req,
        input  resp, rdata, fault
    );

    modport slave (
        input  addr, w_rb, acc, wdata, req,
        output resp, rdata, fault
    );

endinterface
`default_nettype wire

// File: rtl/bus_arb2_slot.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb2_slot
// Description : One-deep request buffer: pending flag, latched payload and a
//               registered fault pulse for requests arriving while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arb2_slot
    import bus_arb2_pkg::*;
#(
    parameter int AW    = c_xlen,
    parameter int DW    = c_xlen,
    parameter int ACC_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_req,
    input  logic [AW-1:0]    i_addr,
    input  logic             i_w_rb,
    input  logic [ACC_W-1:0] i_acc,
    input  logic [DW-1:0]    i_wdata,
    input  logic             i_clr,
    output logic             o_pend,
    output logic             o_viol,
    output logic [AW-1:0]    o_addr,
    output logic             o_w_rb,
    output logic [ACC_W-1:0] o_acc,
    output logic [DW-1:0]    o_wdata
);

    logic             r_pend;
    logic             r_viol;
    logic [AW-1:0]    r_addr;
    logic             r_w_rb;
    logic [ACC_W-1:0] r_acc;
    logic [DW-1:0]    r_wdata;

    // The slot stays busy from capture until its response, so a request in
    // the completion cycle itself is still a violation.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pend  <= 1'b0;
            r_viol  <= 1'b0;
            r_addr  <= '0;
            r_w_rb  <= 1'b0;
            r_acc   <= '0;
            r_wdata <= '0;
        end else begin
            r_viol <= i_req & r_pend;
            if (i_req && !r_pend) begin
                r_pend  <= 1'b1;
                r_addr  <= i_addr;
                r_w_rb  <= i_w_rb;
                r_acc   <= i_acc;
                r_wdata <= i_wdata;
            end else if (i_clr) begin
                r_pend  <= 1'b0;
            end
        end
    end

    assign o_pend  = r_pend;
    assign o_viol  = r_viol;
    assign o_addr  = r_addr;
    assign o_w_rb  = r_w_rb;
    assign o_acc   = r_acc;
    assign o_wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/bus_arb2.sv
`default_nettype none
// ============================================================================
// Module      : bus_arb2
// Description : Shares one single-ported slave between ibus and dbus: buffers
//               one request per side, arbitrates, routes response to owner.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arb2
    import bus_arb2_pkg::*;
#(
    parameter int AW     = c_xlen,
    parameter int DW     = c_xlen,
    parameter int ACC_W  = 2,
    parameter int ARB_RR = c_arb_rr
) (
    input  logic        clk,
    input  logic        rstn,
    bus_arb2_if.slave   i_ibus,
    bus_arb2_if.slave   i_dbus,
    bus_arb2_if.master  o_sbus
);

    state_t           r_state;
    state_t           w_next;
    logic             r_last_i;

    logic             w_pend_i, w_pend_d;
    logic             w_viol_i, w_viol_d;
    logic [AW-1:0]    w_addr_i, w_addr_d;
    logic             w_wrb_i,  w_wrb_d;
    logic [ACC_W-1:0] w_acc_i,  w_acc_d;
    logic [DW-1:0]    w_wdat_i, w_wdat_d;

    logic             w_grant;
    logic             w_win_d;
    logic             w_sel_d;
    logic             w_drive;
    logic             w_resp_i;
    logic             w_resp_d;

    bus_arb2_slot #(.AW(AW), .DW(DW), .ACC_W(ACC_W)) u_slot_i (
        .clk     (clk),
        .rstn    (rstn),
        .i_req   (i_ibus.req),
        .i_addr  (i_ibus.addr),
        .i_w_rb  (i_ibus.w_rb),
        .i_acc   (i_ibus.acc),
        .i_wdata (i_ibus.wdata),
        .i_clr   (w_resp_i),
        .o_pend  (w_pend_i),
        .o_viol  (w_viol_i),
        .o_addr  (w_addr_i),
        .o_w_rb  (w_wrb_i),
        .o_acc   (w_acc_i),
        .o_wdata (w_wdat_i)
    );

    bus_arb2_slot #(.AW(AW), .DW(DW), .ACC_W(ACC_W)) u_slot_d (
        .clk     (clk),
        .rstn    (rstn),
        .i_req   (i_dbus.req),
        .i_addr  (i_dbus.addr),
        .i_w_rb  (i_dbus.w_rb),
        .i_acc   (i_dbus.acc),
        .i_wdata (i_dbus.wdata),
        .i_clr   (w_resp_d),
        .o_pend  (w_pend_d),
        .o_viol  (w_viol_d),
        .o_addr  (w_addr_d),
        .o_w_rb  (w_wrb_d),
        .o_acc   (w_acc_d),
        .o_wdata (w_wdat_d)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= ST_IDLE;
            r_last_i <= 1'b1;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_last_i <= ~w_win_d;
            end
        end
    end

    // A grant is only possible from IDLE, so s_req can never repeat back to back.
    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_win_d  = pick_dbus(w_pend_i, w_pend_d, r_last_i, ARB_RR != 0);
        w_sel_d  = 1'b0;
        w_drive  = 1'b0;
        w_resp_i = 1'b0;
        w_resp_d = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_i || w_pend_d) begin
                    w_grant = 1'b1;
                    w_drive = 1'b1;
                    w_sel_d = w_win_d;
                    w_next  = w_win_d ? ST_WAIT_D : ST_WAIT_I;
                end
            end
            ST_WAIT_I: begin
                w_drive = 1'b1;
                if (o_sbus.resp) begin
                    w_resp_i = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            ST_WAIT_D: begin
                w_drive = 1'b1;
                w_sel_d = 1'b1;
                if (o_sbus.resp) begin
                    w_resp_d = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are forced low while rstn is held so nothing leaks mid-reset.
    assign o_sbus.req   = rstn & w_grant;
    assign o_sbus.addr  = (rstn && w_drive) ? (w_sel_d ? w_addr_d : w_addr_i) : '0;
    assign o_sbus.w_rb  = (rstn && w_drive) ? (w_sel_d ? w_wrb_d  : w_wrb_i)  : 1'b0;
    assign o_sbus.acc   = (rstn && w_drive) ? (w_sel_d ? w_acc_d  : w_acc_i)  : '0;
    assign o_sbus.wdata = (rstn && w_drive) ? (w_sel_d ? w_wdat_d : w_wdat_i) : '0;

    assign i_ibus.resp  = rstn & w_resp_i;
    assign i_ibus.rdata = (rstn && w_resp_i && !w_wrb_i) ? o_sbus.rdata : '0;
    assign i_ibus.fault = rstn & (w_viol_i | (w_resp_i & o_sbus.fault));

    assign i_dbus.resp  = rstn & w_resp_d;
    assign i_dbus.rdata = (rstn && w_resp_d && !w_wrb_d) ? o_sbus.rdata : '0;
    assign i_dbus.fault = rstn & (w_viol_d | (w_resp_d & o_sbus.fault));

endmodule
`default_nettype wire

// File: tb/tb_bus_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arb2
// Description : Self-checking bench: fixed-priority and round-robin arbiters
//               side by side against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arb2;
    import bus_arb2_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int AC = 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    bus_arb2_if #(.AW(AW), .DW(DW), .ACC_W(AC)) ib ();
    bus_arb2_if #(.AW(AW), .DW(DW), .ACC_W(AC)) db ();
    bus_arb2_if #(.AW(AW), .DW(DW), .ACC_W(AC)) ib0 ();
    bus_arb2_if #(.AW(AW), .DW(DW), .ACC_W(AC)) db0 ();
    bus_arb2_if #(.AW(AW), .DW(DW), .ACC_W(AC)) sb0 ();
    bus_arb2_if #(.AW(AW), .DW(DW), .ACC_W(AC)) sb1 ();

    assign ib0.req = ib.req;  assign ib0.addr = ib.addr;  assign ib0.w_rb = ib.w_rb;
    assign ib0.acc = ib.acc;  assign ib0.wdata = ib.wdata;
    assign db0.req = db.req;  assign db0.addr = db.addr;  assign db0.w_rb = db.w_rb;
    assign db0.acc = db.acc;  assign db0.wdata = db.wdata;

    bus_arb2 #(.AW(AW), .DW(DW), .ACC_W(AC), .ARB_RR(0)) u_dut0 (
        .clk(clk), .rstn(rstn), .i_ibus(ib0), .i_dbus(db0), .o_sbus(sb0));
    bus_arb2 #(.AW(AW), .DW(DW), .ACC_W(AC), .ARB_RR(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .i_ibus(ib), .i_dbus(db), .o_sbus(sb1));

    // Observed outputs, indexed [dut][side] with side 0 = ibus, 1 = dbus.
    logic          ob_sreq[2];
    logic [AW-1:0] ob_saddr[2];
    logic          ob_swrb[2];
    logic [AC-1:0] ob_sacc[2];
    logic [DW-1:0] ob_swd[2];
    logic          ob_resp[2][2];
    logic [DW-1:0] ob_rdata[2][2];
    logic          ob_fault[2][2];

    always_comb begin
        ob_sreq[0] = sb0.req;  ob_saddr[0] = sb0.addr;  ob_swrb[0] = sb0.w_rb;
        ob_sacc[0] = sb0.acc;  ob_swd[0]   = sb0.wdata;
        ob_sreq[1] = sb1.req;  ob_saddr[1] = sb1.addr;  ob_swrb[1] = sb1.w_rb;
        ob_sacc[1] = sb1.acc;  ob_swd[1]   = sb1.wdata;
        ob_resp[0][0] = ib0.resp; ob_rdata[0][0] = ib0.rdata; ob_fault[0][0] = ib0.fault;
        ob_resp[0][1] = db0.resp; ob_rdata[0][1] = db0.rdata; ob_fault[0][1] = db0.fault;
        ob_resp[1][0] = ib.resp;  ob_rdata[1][0] = ib.rdata;  ob_fault[1][0] = ib.fault;
        ob_resp[1][1] = db.resp;  ob_rdata[1][1] = db.rdata;  ob_fault[1][1] = db.fault;
    end

    // Requester stimulus (shared by both DUTs) and per-DUT slave stimulus.
    bit            rq[2];
    logic [AW-1:0] ra[2];
    logic          rw[2];
    logic [AC-1:0] rc[2];
    logic [DW-1:0] rdw[2];
    bit            sr[2];
    logic [DW-1:0] srd[2];
    bit            sf[2];

    // Reference model: buffered transactions per side, current slave owner.
    bit            pv[2][2];
    logic [AW-1:0] pa[2][2];
    logic          pw[2][2];
    logic [AC-1:0] pc[2][2];
    logic [DW-1:0] pd[2][2];
    bit            vf[2][2];
    int            own[2]  = '{-1, -1};
    int            last[2] = '{0, 0};
    int            wcnt[2] = '{0, 0};
    int            eg[2];
    bit            er[2][2];

    int  fix_lat    = -1;
    int  fix_fault  = -1;
    bit  fix_rd_en  = 1'b0;
    logic [DW-1:0] fix_rd = '0;
    bit  rand_stray = 1'b0;
    bit  stray_now  = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic apply_inputs();
        ib.req = rq[0]; ib.addr = ra[0]; ib.w_rb = rw[0]; ib.acc = rc[0]; ib.wdata = rdw[0];
        db.req = rq[1]; db.addr = ra[1]; db.w_rb = rw[1]; db.acc = rc[1]; db.wdata = rdw[1];
        sb0.resp = sr[0]; sb0.rdata = srd[0]; sb0.fault = sf[0];
        sb1.resp = sr[1]; sb1.rdata = srd[1]; sb1.fault = sf[1];
    endtask

    task automatic set_req(input int x, input logic [AW-1:0] a, input logic w,
                           input logic [AC-1:0] c, input logic [DW-1:0] d);
        rq[x] = 1'b1; ra[x] = a; rw[x] = w; rc[x] = c; rdw[x] = d;
    endtask

    // Model view: an idle slave goes to the pending side, dbus on ties unless
    // round-robin picks the side that did not win last time.
    task automatic check(input int k);
        int            g;
        int            side;
        bit            r[2];
        logic [AW-1:0] ea;
        logic          ew;
        logic [AC-1:0] ec;
        logic [DW-1:0] ed;
        logic [DW-1:0] erd[2];
        bit            ef[2];
        g = -1; ea = '0; ew = 1'b0; ec = '0; ed = '0;
        r[0] = 1'b0; r[1] = 1'b0; erd[0] = '0; erd[1] = '0; ef[0] = 1'b0; ef[1] = 1'b0;
        if (rstn) begin
            if (own[k] < 0) begin
                if (pv[k][0] && pv[k][1]) g = (k == 1) ? 1 - last[k] : 1;
                else if (pv[k][1])        g = 1;
                else if (pv[k][0])        g = 0;
            end
            side = (own[k] >= 0) ? own[k] : g;
            if (side >= 0) begin
                ea = pa[k][side]; ew = pw[k][side]; ec = pc[k][side]; ed = pd[k][side];
            end
            for (int x = 0; x < 2; x++) begin
                r[x]   = (own[k] == x) && sr[k];
                erd[x] = (r[x] && !pw[k][x]) ? srd[k] : '0;
                ef[x]  = vf[k][x] | (r[x] & sf[k]);
            end
        end
        eg[k] = g; er[k][0] = r[0]; er[k][1] = r[1];
        chk("s_req",   k, 64'(ob_sreq[k]),  64'(g >= 0));
        chk("s_addr",  k, 64'(ob_saddr[k]), 64'(ea));
        chk("s_w_rb",  k, 64'(ob_swrb[k]),  64'(ew));
        chk("s_acc",   k, 64'(ob_sacc[k]),  64'(ec));
        chk("s_wdata", k, 64'(ob_swd[k]),   64'(ed));
        chk("i_resp",  k, 64'(ob_resp[k][0]),  64'(r[0]));
        chk("i_rdata", k, 64'(ob_rdata[k][0]), 64'(erd[0]));
        chk("i_fault", k, 64'(ob_fault[k][0]), 64'(ef[0]));
        chk("d_resp",  k, 64'(ob_resp[k][1]),  64'(r[1]));
        chk("d_rdata", k, 64'(ob_rdata[k][1]), 64'(erd[1]));
        chk("d_fault", k, 64'(ob_fault[k][1]), 64'(ef[1]));
    endtask

    task automatic update();
        for (int k = 0; k < 2; k++) begin
            if (!rstn) begin
                for (int x = 0; x < 2; x++) begin pv[k][x] = 1'b0; vf[k][x] = 1'b0; end
                own[k] = -1; last[k] = 0;
            end else begin
                for (int x = 0; x < 2; x++) begin
                    vf[k][x] = rq[x] && pv[k][x];
                    if (rq[x] && !pv[k][x]) begin
                        pv[k][x] = 1'b1; pa[k][x] = ra[x]; pw[k][x] = rw[x];
                        pc[k][x] = rc[x]; pd[k][x] = rdw[x];
                    end else if (er[k][x]) begin
                        pv[k][x] = 1'b0;
                    end
                end
                if (er[k][0] || er[k][1]) own[k] = -1;
                if (eg[k] >= 0) begin
                    own[k] = eg[k]; last[k] = eg[k];
                    wcnt[k] = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 4));
                end
            end
        end
    endtask

    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            sr[k]  = 1'b0;
            srd[k] = fix_rd_en ? fix_rd : DW'($urandom);
            sf[k]  = (fix_fault >= 0) ? (fix_fault != 0) : ($urandom_range(0, 3) == 0);
            if (own[k] >= 0) begin
                if (wcnt[k] == 0) sr[k] = 1'b1;
                else              wcnt[k]--;
            end else if (stray_now || (rand_stray && $urandom_range(0, 7) == 0)) begin
                sr[k] = 1'b1;
            end
        end
        apply_inputs();
        @(negedge clk);
        check(0);
        check(1);
        @(posedge clk);
        update();
        cyc++;
        #1;
        stray_now = 1'b0;
        for (int x = 0; x < 2; x++) begin
            rq[x] = 1'b0; ra[x] = AW'($urandom); rw[x] = 1'($urandom);
            rc[x] = AC'($urandom); rdw[x] = DW'($urandom);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rstn = 1'b0;
        idle(3);
        rstn = 1'b1;
        idle(2);

        // Uncontended ibus read with a known slave latency and data
        fix_lat = 2; fix_rd_en = 1'b1; fix_rd = 32'hDEAD_BEEF; fix_fault = 0;
        set_req(0, 32'h0000_0100, 1'b0, c_acc_word, 32'h0);
        idle(8);

        // Simultaneous requests, twice, to exercise both arbitration policies
        fix_rd_en = 1'b0; fix_lat = 1;
        set_req(0, 32'h0000_0010, 1'b0, c_acc_word, 32'h0);
        set_req(1, 32'h0000_0020, 1'b0, c_acc_half, 32'h0);
        idle(10);
        set_req(0, 32'h0000_0030, 1'b0, c_acc_byte, 32'h0);
        set_req(1, 32'h0000_0040, 1'b1, c_acc_word, 32'hCAFE_0001);
        idle(10);

        // dbus word write answered with a slave fault
        fix_fault = 1;
        set_req(1, 32'h0000_0200, 1'b1, c_acc_word, 32'h1234_5678);
        idle(6);

        // Second dbus request while the first is still pending
        fix_fault = 0; fix_lat = 3;
        set_req(1, 32'h0000_0300, 1'b0, c_acc_word, 32'h0);
        tick();
        set_req(1, 32'h0000_0304, 1'b1, c_acc_word, 32'hFFFF_0000);
        idle(8);

        // Reset in the middle of an ibus transaction, then a stray response
        fix_lat = 6;
        set_req(0, 32'h0000_0400, 1'b0, c_acc_word, 32'h0);
        idle(3);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        stray_now = 1'b1;
        tick();
        idle(2);
        fix_lat = 1;
        set_req(0, 32'h0000_0404, 1'b0, c_acc_word, 32'h0);
        idle(6);

        // ibus request arriving while dbus owns the slave
        fix_lat = 3;
        set_req(1, 32'h0000_0500, 1'b0, c_acc_word, 32'h0);
        idle(2);
        set_req(0, 32'h0000_0600, 1'b1, c_acc_half, 32'hA5A5_5A5A);
        idle(12);

        // Random traffic with stray responses and occasional resets
        fix_lat = -1; fix_fault = -1; rand_stray = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            rstn = ($urandom_range(0, 199) != 0);
            for (int x = 0; x < 2; x++) begin
                if ($urandom_range(0, 3) == 0)
                    set_req(x, AW'($urandom), 1'($urandom), AC'($urandom_range(0, 2)), DW'($urandom));
            end
            tick();
        end
        rstn = 1'b1;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
